// File: rtl/dp3_pkg.sv
// Shared definitions for the dp3 accumulator datapath and its control unit:
// opcodes, A-input select codes and the controller state encoding.
package dp3_pkg;

    localparam logic [2:0] OP_IN   = 3'b000;
    localparam logic [2:0] OP_LDM  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_JPOS = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ASEL_ALU  = 2'd0;
    localparam logic [1:0] ASEL_DP1  = 2'd1;
    localparam logic [1:0] ASEL_MEM  = 2'd2;
    localparam logic [1:0] ASEL_ZERO = 2'd3;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WAIT_IN,
        HALT
    } state_t;

    function automatic logic [2:0] opcode_of(input logic [7:0] word);
        return word[7:5];
    endfunction

endpackage

// File: rtl/dp3_ctrl_pc.sv
// Program counter for dp3_ctrl: increments once per fetched instruction and
// is overwritten by a branch target when a jump is taken.
module dp3_ctrl_pc #(
    parameter int PCW = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inc,
    input  logic           load,
    input  logic [PCW-1:0] target,
    output logic [PCW-1:0] pc
);

    // NOTE: registers are assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            // Natural overflow wraps the last ROM address back to 0.
            pc <= pc + PCW'(1);
        end
    end

endmodule

// File: rtl/dp3_ctrl.sv
// Instruction sequencer for the dp3 accumulator: fetches from a synchronous
// ROM, drives Aload/Sub/Asel, branches on Apos/Aeq0 and handshakes operand entry.
module dp3_ctrl
    import dp3_pkg::*;
#(
    parameter int PCW = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [7:0]     instr,
    input  logic           in_valid,
    input  logic           Apos,
    input  logic           Aeq0,
    output logic [PCW-1:0] pc,
    output logic           Aload,
    output logic           Sub,
    output logic [1:0]     Asel,
    output logic           in_ready,
    output logic           halted
);

    state_t     state;
    logic [7:0] ir;
    logic [2:0] op;
    logic       taken;
    logic       pc_inc;
    logic       pc_load;

    assign op = opcode_of(ir);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE: begin
                    ir    <= instr;
                    state <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_IN:   state <= WAIT_IN;
                        OP_HALT: state <= HALT;
                        default: state <= FETCH;
                    endcase
                end
                WAIT_IN: if (in_valid) state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        taken = 1'b0;
        case (op)
            OP_JZ:   taken = Aeq0;
            OP_JPOS: taken = Apos;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign pc_inc  = (state == DECODE);
    assign pc_load = (state == EXEC) && taken;

    dp3_ctrl_pc #(.PCW(PCW)) u_pc (
        .clock  (clock),
        .reset  (reset),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (PCW'(ir[4:0])),
        .pc     (pc)
    );

    // Datapath controls are decoded from state and IR so that the operand
    // load in WAIT_IN happens in the same cycle the enter key is seen.
    always_comb begin
        Aload = 1'b0;
        Sub   = 1'b0;
        Asel  = ASEL_ALU;
        case (state)
            EXEC: begin
                case (op)
                    OP_LDM: begin
                        Aload = 1'b1;
                        Asel  = ASEL_MEM;
                    end
                    OP_ADD: Aload = 1'b1;
                    OP_SUB: begin
                        Aload = 1'b1;
                        Sub   = 1'b1;
                    end
                    default: Aload = 1'b0;
                endcase
            end
            WAIT_IN: begin
                if (in_valid) begin
                    Aload = 1'b1;
                    Asel  = ASEL_DP1;
                end
            end
            default: Aload = 1'b0;
        endcase
    end

    assign in_ready = (state == WAIT_IN);
    // halted is raised already in the EXEC cycle of HALT, one cycle before
    // the HALT state itself is entered.
    assign halted   = (state == HALT) || ((state == EXEC) && (op == OP_HALT));

endmodule

// File: tb/tb_dp3_ctrl.sv
// Bench for dp3_ctrl: ROM + accumulator model around the DUT, an ISA-level
// reference model that predicts every A load and the halt point.
module tb_dp3_ctrl;
    import dp3_pkg::*;

    typedef struct {
        logic [1:0] asel;
        logic       sub;
        logic [7:0] a;
    } load_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instr;
    logic       in_valid;
    logic       Apos;
    logic       Aeq0;
    logic [4:0] pc;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic       in_ready;
    logic       halted;

    logic [7:0] rom [32];
    logic [7:0] m_input;
    logic [7:0] dp1_in;
    logic [7:0] acc;

    load_t exp_q[$];
    load_t e;
    int    k_list[$];
    int    exp_halt_pc;
    int    exp_halt_cyc;
    int    vectors = 0;
    int    miscompares = 0;
    int    test_id = 0;
    int    cyc = 0;
    int    kdrv = 0;
    bit    run_active = 0;
    bit    seen_halt = 0;
    bit    chk_a = 0;
    bit    noise = 0;
    logic [7:0] pend_a;

    dp3_ctrl #(.PCW(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .instr    (instr),
        .in_valid (in_valid),
        .Apos     (Apos),
        .Aeq0     (Aeq0),
        .pc       (pc),
        .Aload    (Aload),
        .Sub      (Sub),
        .Asel     (Asel),
        .in_ready (in_ready),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) instr <= rom[pc];

    // Behavioural dp3 accumulator (n=8).
    always @(posedge clock or negedge reset) begin
        if (!reset) acc <= 8'd0;
        else if (Aload) begin
            case (Asel)
                2'd0:    acc <= Sub ? acc - dp1_in : acc + dp1_in;
                2'd1:    acc <= dp1_in;
                2'd2:    acc <= m_input;
                default: acc <= 8'd0;
            endcase
        end
    end
    assign Apos = !acc[7] && (acc != 8'd0);
    assign Aeq0 = (acc == 8'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL test %0d %s: got %0d expected %0d", test_id, name, act, expv);
        end
    endtask

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] tgt);
        return {op, tgt};
    endfunction

    // Instruction-level interpreter: walks the program, recording each A load
    // and the cycle/pc at which halted is first expected.
    task automatic build_model();
        int p = 0;
        int a = 0;
        int t = 0;
        int kidx = 0;
        int k;
        logic [7:0] w;
        int tgt;
        exp_q.delete();
        exp_halt_pc  = -1;
        exp_halt_cyc = -1;
        for (int n = 0; n < 500; n++) begin
            w   = rom[p];
            tgt = int'(w[4:0]);
            p   = (p + 1) % 32;
            case (w[7:5])
                OP_IN: begin
                    k = (kidx < k_list.size()) ? k_list[kidx] : 0;
                    kidx++;
                    a = dp1_in;
                    exp_q.push_back('{ASEL_DP1, 1'b0, 8'(a)});
                    t += 4 + k;
                end
                OP_LDM: begin
                    a = m_input;
                    exp_q.push_back('{ASEL_MEM, 1'b0, 8'(a)});
                    t += 3;
                end
                OP_ADD: begin
                    a = (a + dp1_in) % 256;
                    exp_q.push_back('{ASEL_ALU, 1'b0, 8'(a)});
                    t += 3;
                end
                OP_SUB: begin
                    a = (a - dp1_in + 256) % 256;
                    exp_q.push_back('{ASEL_ALU, 1'b1, 8'(a)});
                    t += 3;
                end
                OP_JZ:   begin if (a == 0) p = tgt; t += 3; end
                OP_JPOS: begin if (a >= 1 && a <= 127) p = tgt; t += 3; end
                OP_JMP:  begin p = tgt; t += 3; end
                default: begin
                    exp_halt_pc  = p;
                    exp_halt_cyc = t + 3;
                    return;
                end
            endcase
        end
    endtask

    // Operand driver: answers each WAIT_IN after the next scheduled number of
    // idle cycles; optionally toggles in_valid while the DUT is not waiting.
    initial begin
        bit waiting = 0;
        int wleft = 0;
        in_valid = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                in_valid = 1'b0;
                waiting  = 0;
            end else if (in_ready) begin
                if (!waiting) begin
                    waiting = 1;
                    wleft   = (kdrv < k_list.size()) ? k_list[kdrv] : 0;
                    kdrv++;
                end
                if (wleft == 0) begin
                    in_valid = 1'b1;
                    waiting  = 0;
                end else begin
                    in_valid = 1'b0;
                    wleft--;
                end
            end else begin
                in_valid = noise && ($urandom_range(0, 3) == 0);
                waiting  = 0;
            end
        end
    end

    // Monitor: pops an expected load on every Aload and checks the
    // resulting A one cycle later; checks the halt point and its hold.
    always @(negedge clock) begin
        if (reset && run_active) begin
            cyc++;
            if (chk_a) begin
                check("acc", 32'(acc), 32'(pend_a));
                chk_a = 0;
            end
            if (Aload) begin
                if (exp_q.size() == 0) begin
                    check("extra_load", 32'(Aload), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("asel", 32'(Asel), 32'(e.asel));
                    check("sub", 32'(Sub), 32'(e.sub));
                    pend_a = e.a;
                    chk_a  = 1;
                end
            end else begin
                check("idle_sub", 32'(Sub), 32'd0);
                check("idle_asel", 32'(Asel), 32'd0);
            end
            if (halted && !seen_halt) begin
                seen_halt = 1;
                check("halt_pc", 32'(pc), 32'(exp_halt_pc));
                check("halt_cycle", 32'(cyc), 32'(exp_halt_cyc));
            end else if (seen_halt) begin
                check("halt_hold", 32'(halted), 32'd1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_aload"}, 32'(Aload), 32'd0);
        check({tag, "_sub"}, 32'(Sub), 32'd0);
        check({tag, "_asel"}, 32'(Asel), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic arm_run();
        build_model();
        cyc       = 0;
        chk_a     = 0;
        seen_halt = 0;
        kdrv      = 0;
        run_active = 1;
    endtask

    // abort_cyc > 0 pulls reset in that cycle, then reruns the program.
    task automatic run_test(input int abort_cyc);
        test_id++;
        run_active = 0;
        reset = 1'b0;
        @(posedge clock);
        #2;
        check_reset_outputs("rst");
        arm_run();
        reset = 1'b1;
        if (abort_cyc > 0) begin
            repeat (abort_cyc - 1) @(posedge clock);
            #1;
            check("pre_abort_aload", 32'(Aload), 32'd1);
            #1;
            reset = 1'b0;
            #1;
            check_reset_outputs("abort");
            run_active = 0;
            @(posedge clock);
            #2;
            arm_run();
            reset = 1'b1;
        end
        for (int i = 0; i < 3000 && !seen_halt; i++) @(posedge clock);
        if (!seen_halt) check("halt_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clock);
        check("loads_left", 32'(exp_q.size()), 32'd0);
        run_active = 0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = ins(OP_HALT, 5'd0);
    endtask

    initial begin
        int len;
        logic [2:0] op;
        m_input = 8'd0;
        dp1_in  = 8'd0;
        clear_rom();

        // LDM then HALT.
        m_input = 8'd10; k_list = {}; noise = 0;
        rom[0] = ins(OP_LDM, 5'd0);
        run_test(0);

        // IN, ADD, SUB, HALT with the operand entered two cycles late.
        clear_rom();
        dp1_in = 8'd20; k_list = {2};
        rom[0] = ins(OP_IN, 5'd0);
        rom[1] = ins(OP_ADD, 5'd0);
        rom[2] = ins(OP_SUB, 5'd0);
        run_test(0);

        // Countdown loop.
        clear_rom();
        m_input = 8'd3; dp1_in = 8'd1; k_list = {};
        rom[0] = ins(OP_LDM, 5'd0);
        rom[1] = ins(OP_SUB, 5'd0);
        rom[2] = ins(OP_JZ, 5'd4);
        rom[3] = ins(OP_JMP, 5'd1);
        run_test(0);

        // JPOS on a negative and a positive accumulator.
        clear_rom();
        rom[0] = ins(OP_LDM, 5'd0);
        rom[1] = ins(OP_JPOS, 5'd3);
        rom[2] = ins(OP_HALT, 5'd0);
        m_input = 8'h80;
        run_test(0);
        m_input = 8'd5;
        run_test(0);

        // JMP to the last address, then wrap to 0.
        clear_rom();
        m_input = 8'd3; dp1_in = 8'd0;
        rom[0]  = ins(OP_JPOS, 5'd4);
        rom[1]  = ins(OP_LDM, 5'd0);
        rom[2]  = ins(OP_JMP, 5'd31);
        rom[31] = ins(OP_ADD, 5'd0);
        run_test(0);

        // Two INs with in_valid noise outside WAIT_IN.
        clear_rom();
        dp1_in = 8'd33; k_list = {1, 0}; noise = 1;
        rom[0] = ins(OP_IN, 5'd0);
        rom[1] = ins(OP_IN, 5'd0);
        rom[2] = ins(OP_ADD, 5'd0);
        run_test(0);
        noise = 0;

        // Reset in the EXEC cycle of ADD.
        clear_rom();
        m_input = 8'd5; dp1_in = 8'd7; k_list = {};
        rom[0] = ins(OP_LDM, 5'd0);
        rom[1] = ins(OP_ADD, 5'd0);
        run_test(6);

        // Random forward-branching programs.
        for (int r = 0; r < 20; r++) begin
            clear_rom();
            len = $urandom_range(3, 20);
            for (int a = 0; a < len - 1; a++) begin
                op = 3'($urandom_range(0, 6));
                if (op == OP_JZ || op == OP_JPOS || op == OP_JMP)
                    rom[a] = ins(op, 5'($urandom_range(a + 1, len - 1)));
                else
                    rom[a] = ins(op, 5'($urandom_range(0, 31)));
            end
            m_input = 8'($urandom_range(0, 255));
            dp1_in  = 8'($urandom_range(0, 255));
            k_list  = {};
            for (int i = 0; i < 40; i++) k_list.push_back($urandom_range(0, 3));
            noise = 1'($urandom_range(0, 1));
            run_test(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dp3_ctrl.md
# dp3_ctrl

Control unit for the `dp3` accumulator datapath. It fetches 8-bit instructions from an external synchronous program ROM and sequences `Aload`, `Sub`, and `Asel` into `dp3`. It branches on the `Apos`/`Aeq0` status returned by `dp3`, and handshakes operand entry from the user-input side that drives `dp1In`. Together with `dp3` and the ROM it forms the Lab 2 processor.

## Interface
- `PCW`, default 5: program-counter width; the ROM holds 2^PCW words.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `instr` input 8: ROM data; valid one cycle after `pc` is presented.
- `in_valid` input 1: user operand on `dp1In` is valid (enter key).
- `Apos` input 1: `dp3` status; A is positive.
- `Aeq0` input 1: `dp3` status; A is zero.
- `pc` output PCW: ROM address.
- `Aload` output 1: `dp3` accumulator load enable.
- `Sub` output 1: `dp3` ALU mode; 1 = A − dp1In, 0 = A + dp1In.
- `Asel` output 2: `dp3` A-input select. 0 = ALU result (ProdSub), 1 = dp1In, 2 = mInput, 3 = zero.
- `in_ready` output 1: controller is waiting for a user operand.
- `halted` output 1: HALT executed.

## Operation
- Instruction format: `instr[7:5]` is the opcode, `instr[4:0]` is the jump target (the low PCW bits are used).
- Opcodes:
  - 000 IN: wait for operand, then A ← dp1In.
  - 001 LDM: A ← mInput.
  - 010 ADD: A ← A + dp1In.
  - 011 SUB: A ← A − dp1In.
  - 100 JZ: if `Aeq0`, pc ← target.
  - 101 JPOS: if `Apos`, pc ← target.
  - 110 JMP: pc ← target.
  - 111 HALT.
- FSM states: FETCH, DECODE, EXEC, WAIT_IN, HALT.
  - FETCH: `pc` is presented to the ROM; go to DECODE.
  - DECODE: IR ← `instr`; pc ← pc+1, wrapping at 2^PCW−1 to 0; go to EXEC.
  - EXEC: perform the opcode. IN goes to WAIT_IN, HALT goes to HALT, all others go to FETCH.
  - WAIT_IN: `in_ready`=1. When `in_valid` is sampled high, go to FETCH; otherwise stay.
  - HALT: `halted`=1; stays until reset. `Aload`=0 permanently.
- Output decode (combinational from state and IR; Moore with respect to the IR):
  - EXEC+LDM: `Aload`=1, `Asel`=2.
  - EXEC+ADD: `Aload`=1, `Asel`=0, `Sub`=0.
  - EXEC+SUB: `Aload`=1, `Asel`=0, `Sub`=1.
  - WAIT_IN with `in_valid`=1: `Aload`=1, `Asel`=1.
  - All other cycles: `Aload`=0, `Sub`=0, `Asel`=0.
- A taken branch overwrites the incremented pc in EXEC. A not-taken branch keeps pc+1.
- Branch status is sampled in the EXEC cycle. A was last loaded at least 2 cycles earlier, so `Apos`/`Aeq0` are settled.
- `in_valid` outside WAIT_IN is ignored and not latched. If `in_valid` is held high across a second IN instruction, that IN completes on its first WAIT_IN cycle.

## Timing
- Reset values (asynchronous): state=FETCH, pc=0, IR=0, `Aload`=0, `Sub`=0, `Asel`=0, `in_ready`=0, `halted`=0.
- After reset release, the first FETCH occurs on the first rising edge.
- Non-IN instructions take exactly 3 cycles: FETCH, DECODE, EXEC.
- IN takes 3 cycles plus the number of WAIT_IN cycles with `in_valid`=0. The minimum is 4 cycles when `in_valid` is already high.
- `Aload` is high for exactly one cycle per load instruction. A updates on the edge ending that cycle.
- Reset asserted mid-instruction aborts it immediately. No partial `Aload` is issued after reset falls.

## Structure
- Shared package `dp3_pkg` holds:
  - opcode constants (OP_IN … OP_HALT),
  - `Asel` constants (ASEL_ALU=0, ASEL_DP1=1, ASEL_MEM=2, ASEL_ZERO=3),
  - the state enum.
- The package is shared with `dp3` and the top level.
- One sub-module, `dp3_ctrl_pc`, contains the pc register with increment, wrap, and load-target.
- The FSM and output decode live in `dp3_ctrl`.
- The bench uses a behavioural 32×8 synchronous ROM plus a `dp3` instance with n=8.

## Test plan
- Reset, then release with ROM = {LDM, HALT} and mInput=10:
  - `Aload`=1 with `Asel`=2 in cycle 3; A=10.
  - `halted`=1 from cycle 6 onward; pc=2.
- Program IN, ADD, SUB, HALT with dp1In=20 and `in_valid` asserted 2 cycles after `in_ready` rises:
  - A=20, then 40, then 20.
  - IN takes 6 cycles.
  - `Sub`=1 only in the SUB EXEC cycle.
- Countdown program LDM(mInput=3), SUB(dp1In=1), JZ 4, JMP 1, HALT:
  - A steps 3→2→1→0.
  - JZ is taken only when A=0; halts at pc=5.
- JPOS with A=0x80 (negative) is not taken, and with A=5 is taken. JMP to 31 followed by a non-jump wraps pc to 0.
- `in_valid` pulsed during FETCH/DECODE of an IN is ignored: the controller remains in WAIT_IN, and A changes only on a later `in_valid`.
- `reset` asserted in the EXEC cycle of ADD: outputs go to reset values immediately, A is not loaded, and execution restarts from pc=0.
